// File: rtl/sample_mixer_scheduler_if.sv
// Voice/mix bus between the frame sequencer and its environment.
// master: the scheduler; slave: divider, oscillator and output stage.
interface sample_mixer_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8
);
  localparam int IDX_W = $clog2(NUM_VOICES);

  logic                  enable;
  logic                  sample_now;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  voice_req;
  logic [IDX_W-1:0]      voice_sel;
  logic                  voice_ack;
  logic [SAMPLE_W-1:0]   voice_sample;
  logic [SAMPLE_W-1:0]   mix_out;
  logic                  mix_valid;
  logic                  busy;
  logic                  overrun;
  logic                  clear_overrun;

  modport master (
    input  enable, sample_now, voice_active,
    input  voice_ack, voice_sample, clear_overrun,
    output voice_req, voice_sel, mix_out,
    output mix_valid, busy, overrun
  );

  modport slave (
    output enable, sample_now, voice_active,
    output voice_ack, voice_sample, clear_overrun,
    input  voice_req, voice_sel, mix_out,
    input  mix_valid, busy, overrun
  );
endinterface

// File: rtl/sample_mixer_scheduler.sv
// Per-frame voice walker: requests each active voice from the shared
// oscillator, sums the samples and emits their truncated average.
// Ports: clk, rst (async, active-high), bus (master modport).
module sample_mixer_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  sample_mixer_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE, SELECT, WAIT, DONE
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ACC_W-1:0]      acc_q;
  logic [NUM_VOICES-1:0] mask_q;
  logic [SAMPLE_W-1:0]   mix_q;
  logic                  mix_valid_q;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  busy;
  logic [ACC_W-1:0]      acc_sum;

  assign busy    = (state_q != IDLE);
  assign acc_sum = acc_q + ACC_W'(bus.voice_sample);

  // A dropped strobe must win over a same-cycle clear.
  assign overrun_d = (busy && bus.sample_now) ||
                     (overrun_q && !bus.clear_overrun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;
      overrun_q   <= overrun_d;
      if (busy && !bus.enable) begin
        // Abort: withdraw the request, keep the old mix.
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.sample_now && bus.enable) begin
              mask_q  <= bus.voice_active;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= SELECT;
            end
          end
          SELECT: begin
            if (mask_q[idx_q]) begin
              state_q <= WAIT;
            end else if (idx_q == LAST) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          WAIT: begin
            if (bus.voice_ack) begin
              acc_q <= acc_sum;
              if (idx_q == LAST) begin
                state_q <= DONE;
              end else begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= SELECT;
              end
            end
          end
          DONE: begin
            // Upper SAMPLE_W bits = acc >> IDX_W.
            mix_q       <= acc_q[ACC_W-1:IDX_W];
            mix_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.voice_req = (state_q == WAIT);
  assign bus.voice_sel = idx_q;
  assign bus.mix_out   = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sample_mixer_scheduler.sv
// Directed bench for sample_mixer_scheduler.
// Drives frames through the bus and checks timing and mix values.
module tb_sample_mixer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sample_mixer_scheduler_if #(.NUM_VOICES(4), .SAMPLE_W(8)) bus();

  sample_mixer_scheduler #(.NUM_VOICES(4), .SAMPLE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the current cycle (state IDLE); runs 30 cycles.
  task automatic run_frame(
    input  logic [3:0]  mask,
    input  logic [31:0] smp,
    input  logic [15:0] kd,
    input  int          strobe_at,
    input  int          clr_at,
    input  int          abort_at,
    input  bit          toggle,
    output int          vcyc,
    output int          pulses,
    output logic [7:0]  out,
    output bit          bad_req,
    output bit          unstable,
    output logic        ab_req,
    output logic        ab_busy
  );
    int w;
    logic preq;
    logic [1:0] psel;
    vcyc = -1; pulses = 0; out = 8'h00;
    bad_req = 0; unstable = 0;
    ab_req = 1'bx; ab_busy = 1'bx;
    w = 0; preq = 1'b0; psel = 2'd0;
    bus.voice_active = mask;
    bus.enable = 1'b1;
    bus.sample_now = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus.sample_now = (c == strobe_at);
      bus.clear_overrun = (c == clr_at);
      bus.enable = !(abort_at > 0 && c >= abort_at);
      if (toggle) bus.voice_active = ~bus.voice_active;
      if (bus.mix_valid) begin
        pulses++;
        if (vcyc < 0) begin
          vcyc = c;
          out = bus.mix_out;
        end
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        ab_req = bus.voice_req;
        ab_busy = bus.busy;
      end
      if (bus.voice_req) begin
        if (preq && bus.voice_sel != psel) unstable = 1;
        if (!mask[bus.voice_sel]) bad_req = 1;
        w++;
        bus.voice_ack = (w == int'(kd[4*bus.voice_sel +: 4]));
        bus.voice_sample = bus.voice_ack ?
          smp[8*bus.voice_sel +: 8] : 8'hA5;
      end else begin
        w = 0;
        bus.voice_ack = 1'b0;
        bus.voice_sample = 8'h5A;
      end
      preq = bus.voice_req;
      psel = bus.voice_sel;
    end
    bus.sample_now = 1'b0;
    bus.clear_overrun = 1'b0;
    bus.enable = 1'b1;
    bus.voice_ack = 1'b0;
  endtask

  initial begin
    int vc, np;
    logic [7:0] mo;
    bit br, us;
    logic ar, ab;

    bus.enable = 1'b1;
    bus.sample_now = 1'b0;
    bus.voice_active = 4'h0;
    bus.voice_ack = 1'b0;
    bus.voice_sample = 8'h00;
    bus.clear_overrun = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus.voice_req, 0);
    chk("rst_mix", bus.mix_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All voices inactive.
    run_frame(4'b0000, 32'h44332211, 16'h1111, 0, 0, 0, 0,
              vc, np, mo, br, us, ar, ab);
    chk("idle_vcyc", vc, 6);
    chk("idle_mix", mo, 8'h00);
    chk("idle_pulses", np, 1);
    chk("idle_noreq", br, 0);

    // All active, immediate ack.
    run_frame(4'b1111, 32'h40302010, 16'h1111, 0, 0, 0, 0,
              vc, np, mo, br, us, ar, ab);
    chk("all_vcyc", vc, 10);
    chk("all_mix", mo, 8'h28);
    chk("all_pulses", np, 1);
    chk("all_hold", bus.mix_out, 8'h28);

    // Async reset mid-WAIT.
    bus.voice_active = 4'b1111;
    bus.sample_now = 1'b1;
    @(posedge clk); #1;
    bus.sample_now = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", bus.voice_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", bus.voice_req, 0);
    chk("arst_sel", bus.voice_sel, 0);
    chk("arst_mix", bus.mix_out, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_valid", bus.mix_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    np = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.mix_valid) np++;
    end
    chk("arst_nopulse", np, 0);

    // Full-scale samples must not wrap.
    run_frame(4'b1111, 32'hFFFFFFFF, 16'h1111, 0, 0, 0, 0,
              vc, np, mo, br, us, ar, ab);
    chk("ff_vcyc", vc, 10);
    chk("ff_mix", mo, 8'hFF);

    // Mask 0101, voice 2 acked in third WAIT cycle, mask toggled.
    run_frame(4'b0101, 32'h773C1150, 16'h0301, 0, 0, 0, 1,
              vc, np, mo, br, us, ar, ab);
    chk("m5_vcyc", vc, 10);
    chk("m5_mix", mo, 8'h23);
    chk("m5_stable", us, 0);
    chk("m5_masked", br, 0);

    // Strobe with enable low in IDLE is ignored.
    bus.enable = 1'b0;
    bus.sample_now = 1'b1;
    @(posedge clk); #1;
    bus.sample_now = 1'b0;
    bus.enable = 1'b1;
    chk("dis_busy", bus.busy, 0);
    chk("dis_ovr", bus.overrun, 0);

    // Overrun: strobe during WAIT.
    run_frame(4'b1111, 32'h04040404, 16'h1111, 4, 0, 0, 0,
              vc, np, mo, br, us, ar, ab);
    chk("ovr_vcyc", vc, 10);
    chk("ovr_mix", mo, 8'h04);
    chk("ovr_pulses", np, 1);
    chk("ovr_set", bus.overrun, 1);

    // Clear together with a busy strobe: set wins.
    run_frame(4'b1111, 32'h04040404, 16'h1111, 4, 4, 0, 0,
              vc, np, mo, br, us, ar, ab);
    chk("ovr_setwins", bus.overrun, 1);
    chk("ovr2_vcyc", vc, 10);

    bus.clear_overrun = 1'b1;
    @(posedge clk); #1;
    bus.clear_overrun = 1'b0;
    chk("ovr_clear", bus.overrun, 0);

    // Abort in voice 1 WAIT.
    run_frame(4'b1111, 32'h80808080, 16'h1151, 0, 0, 4, 0,
              vc, np, mo, br, us, ar, ab);
    chk("ab_req", ar, 0);
    chk("ab_busy", ab, 0);
    chk("ab_nopulse", np, 0);
    chk("ab_hold", bus.mix_out, 8'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
